// File: rtl/lcd_phy_pkg.sv
// rtl/lcd_phy_pkg.sv - shared state type and elaboration helpers for the LCD write PHY
package lcd_phy_pkg;

  typedef enum logic [2:0] {
    S_OFF,
    S_IDLE,
    S_WR_LO,
    S_WR_HI,
    S_RST_LO,
    S_RST_WAIT
  } state_t;

  localparam int DW_NARROW = 8;
  localparam int DW_WIDE   = 16;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic bit dw_legal(input int dw);
    return (dw == DW_NARROW) || (dw == DW_WIDE);
  endfunction

endpackage

// File: rtl/lcd_phy_seq_if.sv
// rtl/lcd_phy_seq_if.sv - valid/ready beat stream between the LCD streamer and the PHY
interface lcd_phy_seq_if #(
  parameter int DW = 8
);
  logic [DW-1:0] data;
  logic          rs;
  logic          valid;
  logic          ready;

  modport master (output data, output rs, output valid, input ready);
  modport slave  (input data, input rs, input valid, output ready);
endinterface

// File: rtl/lcd_phy_sync.sv
// rtl/lcd_phy_sync.sv - 2-flop synchroniser with optional debounce and rising-edge strobe
module lcd_phy_sync #(
  parameter int DEB = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic stb
);
  logic s1, s2, prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= q;
    end
  end

  if (DEB == 0) begin : g_raw
    assign q = s2;
  end else begin : g_deb
    localparam int CW = $clog2(DEB + 1);
    logic [CW-1:0] cnt;
    logic          lvl;

    // Any return of s2 to the current level restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB - 1)) begin
        lvl <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign q = lvl;
  end

  assign stb = q & ~prev;
endmodule

// File: rtl/lcd_phy_seq.sv
// rtl/lcd_phy_seq.sv - parametrised parallel-LCD write PHY with reset sequencer and ownership hand-over
module lcd_phy_seq
  import lcd_phy_pkg::*;
#(
  parameter int DW       = 8,
  parameter int WR_LO    = 1,
  parameter int WR_HI    = 1,
  parameter int RST_LO   = 1024,
  parameter int RST_WAIT = 4096,
  parameter int MODE_DEB = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  lcd_phy_seq_if.slave  phy,
  output logic [DW-1:0] lcd_d,
  output logic          lcd_rs,
  output logic          lcd_wr_n,
  output logic          lcd_oe,
  output logic          lcd_cs_drv,
  output logic          lcd_rst_drv,
  input  logic          lcd_mode,
  input  logic          lcd_fmark,
  input  logic          phy_ena,
  input  logic          phy_cs,
  input  logic          phy_rst_req,
  output logic          phy_mode,
  output logic          phy_busy,
  output logic          phy_fmark_stb
);
  localparam int CW = $clog2(max(max(RST_LO, RST_WAIT), max(max(WR_LO, WR_HI), MODE_DEB)) + 1);

  if (!dw_legal(DW) || WR_LO < 1 || WR_HI < 1 || MODE_DEB < 1) begin : g_bad_param
    $error("lcd_phy_seq: DW must be 8 or 16 and WR_LO, WR_HI, MODE_DEB at least 1");
  end

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_load;
  logic          pending, pending_n;
  logic          last, in_wr, accept;
  logic          mode_rise, fmark_lvl, fmark_edge;

  lcd_phy_sync #(.DEB(MODE_DEB)) u_mode_sync (
    .clk(clk), .rst_n(rst_n), .din(lcd_mode), .q(phy_mode), .stb(mode_rise)
  );

  lcd_phy_sync #(.DEB(0)) u_fmark_sync (
    .clk(clk), .rst_n(rst_n), .din(lcd_fmark), .q(fmark_lvl), .stb(fmark_edge)
  );

  assign last  = (cnt == '0);
  assign in_wr = (state == S_WR_LO) || (state == S_WR_HI);
  // A reset request never shares a cycle with an accepted beat.
  assign phy.ready = phy_ena & phy_mode & ~pending & ~phy_rst_req &
                     ((state == S_IDLE) | ((state == S_WR_HI) & last));
  assign accept = phy.valid & phy.ready;

  always_comb begin
    state_n   = state;
    pending_n = pending;
    if (in_wr && phy_rst_req) pending_n = 1'b1;
    case (state)
      S_OFF:      if (mode_rise) state_n = S_IDLE;
      S_IDLE: begin
        if (!phy_mode)                    state_n = S_OFF;
        else if (phy_rst_req || pending)  state_n = S_RST_LO;
        else if (accept)                  state_n = S_WR_LO;
      end
      S_WR_LO:    if (last) state_n = S_WR_HI;
      S_WR_HI: begin
        if (last) begin
          if (!phy_mode)      state_n = S_OFF;
          else if (pending_n) state_n = S_RST_LO;
          else if (accept)    state_n = S_WR_LO;
          else                state_n = S_IDLE;
        end
      end
      S_RST_LO: begin
        if (!phy_mode)  state_n = S_OFF;
        else if (last)  state_n = S_RST_WAIT;
      end
      S_RST_WAIT: begin
        if (!phy_mode)  state_n = S_OFF;
        else if (last)  state_n = S_IDLE;
      end
      default:          state_n = S_OFF;
    endcase
    if (state_n == S_RST_LO || state_n == S_OFF) pending_n = 1'b0;
  end

  always_comb begin
    cnt_load = '0;
    case (state_n)
      S_WR_LO:    cnt_load = CW'(WR_LO - 1);
      S_WR_HI:    cnt_load = CW'(WR_HI - 1);
      S_RST_LO:   cnt_load = CW'(RST_LO - 1);
      S_RST_WAIT: cnt_load = CW'(RST_WAIT - 1);
      default:    cnt_load = '0;
    endcase
  end

  // Pad outputs are decoded from the next state so they leave flops glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_OFF;
      cnt           <= '0;
      pending       <= 1'b0;
      lcd_d         <= '0;
      lcd_rs        <= 1'b0;
      lcd_wr_n      <= 1'b1;
      lcd_oe        <= 1'b0;
      lcd_cs_drv    <= 1'b0;
      lcd_rst_drv   <= 1'b0;
      phy_busy      <= 1'b0;
      phy_fmark_stb <= 1'b0;
    end else begin
      state         <= state_n;
      pending       <= pending_n;
      if (state_n != state) cnt <= cnt_load;
      else if (!last)       cnt <= cnt - 1'b1;
      if (accept) begin
        lcd_d  <= phy.data;
        lcd_rs <= phy.rs;
      end
      lcd_wr_n      <= (state_n != S_WR_LO);
      lcd_rst_drv   <= (state_n == S_RST_LO);
      phy_busy      <= (state_n == S_RST_LO) || (state_n == S_RST_WAIT);
      lcd_oe        <= phy_mode;
      lcd_cs_drv    <= phy_cs & phy_mode;
      phy_fmark_stb <= fmark_edge & fmark_lvl;
    end
  end
endmodule

// File: tb/tb_lcd_phy_seq.sv
// tb/tb_lcd_phy_seq.sv - directed self-checking bench for lcd_phy_seq
module tb_lcd_phy_seq;
  import lcd_phy_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lcd_mode = 1'b0, lcd_fmark = 1'b0;
  logic phy_ena = 1'b0, phy_cs = 1'b0, phy_rst_req = 1'b0;

  logic [7:0]  lcd_d_a;
  logic [15:0] lcd_d_b;
  logic lcd_rs_a, lcd_wr_n_a, lcd_oe_a, lcd_cs_a, lcd_rstd_a, mode_a, busy_a, fstb_a;
  logic lcd_rs_b, lcd_wr_n_b, lcd_oe_b, lcd_cs_b, lcd_rstd_b, mode_b, busy_b, fstb_b;

  lcd_phy_seq_if #(.DW(8))  phy_a ();
  lcd_phy_seq_if #(.DW(16)) phy_b ();

  lcd_phy_seq #(.DW(8), .WR_LO(1), .WR_HI(1), .RST_LO(8), .RST_WAIT(16), .MODE_DEB(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .phy(phy_a), .lcd_d(lcd_d_a), .lcd_rs(lcd_rs_a),
    .lcd_wr_n(lcd_wr_n_a), .lcd_oe(lcd_oe_a), .lcd_cs_drv(lcd_cs_a), .lcd_rst_drv(lcd_rstd_a),
    .lcd_mode(lcd_mode), .lcd_fmark(lcd_fmark), .phy_ena(phy_ena), .phy_cs(phy_cs),
    .phy_rst_req(phy_rst_req), .phy_mode(mode_a), .phy_busy(busy_a), .phy_fmark_stb(fstb_a)
  );

  lcd_phy_seq #(.DW(16), .WR_LO(3), .WR_HI(2), .RST_LO(8), .RST_WAIT(16), .MODE_DEB(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .phy(phy_b), .lcd_d(lcd_d_b), .lcd_rs(lcd_rs_b),
    .lcd_wr_n(lcd_wr_n_b), .lcd_oe(lcd_oe_b), .lcd_cs_drv(lcd_cs_b), .lcd_rst_drv(lcd_rstd_b),
    .lcd_mode(lcd_mode), .lcd_fmark(lcd_fmark), .phy_ena(phy_ena), .phy_cs(phy_cs),
    .phy_rst_req(phy_rst_req), .phy_mode(mode_b), .phy_busy(busy_b), .phy_fmark_stb(fstb_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fcount = 0;
  logic mon_prev_wr = 1'b1;
  logic [8:0] exp_q[$];
  int fstb_q[$];
  int acc_cyc[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_a();
    return {15'd0, lcd_wr_n_a, lcd_d_a, lcd_rs_a, lcd_oe_a, lcd_cs_a, lcd_rstd_a,
            phy_a.ready, busy_a, mode_a, fstb_a};
  endfunction

  // One clock step; scoreboards for dut_a beats and fmark strobes are checked here.
  task automatic tick();
    logic [8:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (mon_prev_wr && !lcd_wr_n_a) begin
      chk("beat expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat rs/data", 32'({lcd_rs_a, lcd_d_a}), 32'(e));
      end
    end
    mon_prev_wr = lcd_wr_n_a;
    if (fstb_a) begin
      fcount++;
      chk("fmark strobe expected", 32'(fstb_q.size() != 0), 32'd1);
      if (fstb_q.size() != 0) chk("fmark strobe cycle", 32'(cyc), 32'(fstb_q.pop_front()));
    end
  endtask

  task automatic send_a(input logic [7:0] d, input logic rs, output int acc);
    logic ok = 1'b0;
    phy_a.valid = 1'b1;
    phy_a.data  = d;
    phy_a.rs    = rs;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (phy_a.ready) ok = 1'b1;
      else tick();
    end
    chk("send_a ready", 32'(ok), 32'd1);
    acc = cyc;
    if (ok) begin
      exp_q.push_back({rs, d});
      tick();
      chk("wr_n low after accept", 32'(lcd_wr_n_a), 32'd0);
    end
    phy_a.valid = 1'b0;
  endtask

  initial begin
    int n;
    int dummy;
    logic dropped;
    int widths[3];
    logic [7:0]  beat_d[4];
    logic        beat_rs[4];

    phy_a.valid = 1'b0; phy_a.data = '0; phy_a.rs = 1'b0;
    phy_b.valid = 1'b0; phy_b.data = '0; phy_b.rs = 1'b0;
    beat_d  = '{8'h2C, 8'h11, 8'h22, 8'h33};
    beat_rs = '{1'b0, 1'b1, 1'b1, 1'b1};
    widths  = '{1, 4, 10};

    tick();
    tick();
    chk("reset state", status_a(), 32'h0001_0000);
    rst_n = 1'b1;
    phy_ena = 1'b1;
    phy_cs  = 1'b1;
    tick();

    // ownership rises 2 + MODE_DEB cycles after lcd_mode
    lcd_mode = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 17) chk("phy_mode before 18", 32'(mode_a), 32'd0);
      if (k == 18) chk("phy_mode at 18", 32'(mode_a), 32'd1);
    end

    for (int i = 0; i < 4; i++) send_a(beat_d[i], beat_rs[i], acc_cyc[i]);
    for (int i = 1; i < 4; i++) chk($sformatf("beat spacing %0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
    tick();
    chk("oe/cs owned", 32'({lcd_oe_a, lcd_cs_a}), 32'b11);

    // 16-bit bus, WR_LO=3, WR_HI=2
    phy_b.valid = 1'b1; phy_b.data = 16'hBEEF; phy_b.rs = 1'b1;
    chk("b ready idle", 32'(phy_b.ready), 32'd1);
    tick();
    phy_b.valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("b wr_n[%0d]", k), 32'(lcd_wr_n_b), 32'(k > 3));
      chk($sformatf("b ready[%0d]", k), 32'(phy_b.ready), 32'(k == 5));
      chk($sformatf("b data[%0d]", k), 32'({lcd_rs_b, lcd_d_b}), 32'h1BEEF);
      if (k < 5) tick();
    end
    repeat (3) tick();

    // reset request in IDLE wins over a simultaneous beat
    phy_rst_req = 1'b1;
    phy_a.valid = 1'b1; phy_a.data = 8'h55; phy_a.rs = 1'b1;
    tick();
    phy_rst_req = 1'b0;
    phy_a.valid = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      chk($sformatf("rst seq[%0d]", k), 32'({busy_a, lcd_rstd_a, phy_a.ready}),
          32'({k <= 24, k <= 8, k == 25}));
      if (k < 25) tick();
    end

    // reset request during WR_LO waits for the beat, then runs immediately
    send_a(8'hA5, 1'b1, dummy);
    phy_rst_req = 1'b1;
    phy_a.valid = 1'b1; phy_a.data = 8'h5A; phy_a.rs = 1'b0;
    tick();
    phy_rst_req = 1'b0;
    chk("ready blocked by pending", 32'(phy_a.ready), 32'd0);
    tick();
    chk("rst after beat", 32'({lcd_rstd_a, lcd_wr_n_a}), 32'b11);
    phy_a.valid = 1'b0;
    n = 0;
    while (!phy_a.ready && n < 40) begin
      tick();
      n++;
    end
    chk("ready after pending reset", 32'(n), 32'd24);

    // short glitch on lcd_mode is filtered
    dropped = 1'b0;
    lcd_mode = 1'b0;
    for (int k = 0; k < 5; k++) begin tick(); if (!mode_a) dropped = 1'b1; end
    lcd_mode = 1'b1;
    for (int k = 0; k < 25; k++) begin tick(); if (!mode_a) dropped = 1'b1; end
    chk("mode glitch filtered", 32'(dropped), 32'd0);

    // lcd_mode low long enough to drop ownership in the middle of a beat
    lcd_mode = 1'b0;
    repeat (16) tick();
    send_a(8'h77, 1'b0, dummy);
    tick();
    chk("mode fell mid-beat", 32'({mode_a, lcd_wr_n_a, lcd_oe_a}), 32'b011);
    tick();
    chk("released after beat", 32'({lcd_oe_a, lcd_cs_a, phy_a.ready}), 32'b000);
    chk("state off", 32'(dut_a.state), 32'(S_OFF));
    repeat (2) tick();
    lcd_mode = 1'b1;

    // tearing-effect strobes: one per rising edge, 3 cycles later
    foreach (widths[i]) begin
      lcd_fmark = 1'b1;
      fstb_q.push_back(cyc + 3);
      repeat (widths[i]) tick();
      lcd_fmark = 1'b0;
      repeat (6) tick();
    end
    chk("fmark strobe count", 32'(fcount), 32'd3);

    // asynchronous reset in the middle of a beat
    send_a(8'hC3, 1'b0, dummy);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset", status_a(), 32'h0001_0000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("beats all seen", 32'(exp_q.size()), 32'd0);
    chk("fmark all seen", 32'(fstb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
